// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - start/done operand and result bundle for seq_alu
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALUResult;
    logic             zero;
    logic             overflow;

    modport master (
        output start, ALUOp, A, B,
        input  busy, done, ALUResult, zero, overflow
    );

    modport slave (
        input  start, ALUOp, A, B,
        output busy, done, ALUResult, zero, overflow
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with iterative multiply/divide and start/done handshake
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     CLK,
    input  logic     Reset,
    seq_alu_if.slave bus
);
    typedef enum logic {IDLE, ITER} state_t;

    // The accept edge already performs the first step, so the counter holds
    // the steps still to run; the edge that takes it from 1 to 0 completes.
    localparam logic [SHW-1:0] ITER_LOAD = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] LAST_STEP = SHW'(1);

    state_t           state_q, state_d;
    logic             accept, iter_op;
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic             op_div_q, op_hi_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, ovf_q, done_q;

    logic [WIDTH-1:0] sum, diff, sc_result;
    logic [SHW-1:0]   shamt;
    logic             sc_ovf;

    logic [WIDTH-1:0] step_hi, step_lo, step_b;
    logic             step_div;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] step_hi_n, step_lo_n, iter_result;

    assign accept  = (state_q == IDLE) && bus.start;
    assign iter_op = bus.ALUOp[3] && (bus.ALUOp[2] ^ bus.ALUOp[1]);

    // single-cycle result and signed overflow from the live operands
    always_comb begin
        sum       = bus.A + bus.B;
        diff      = bus.A - bus.B;
        shamt     = bus.A[SHW-1:0];
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (bus.ALUOp)
            4'b0000: begin
                sc_result = sum;
                sc_ovf    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'b0001: begin
                sc_result = diff;
                sc_ovf    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'b0010: sc_result = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            4'b0011: sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            4'b0100: sc_result = bus.B << shamt;
            4'b0101: sc_result = bus.A | bus.B;
            4'b0110: sc_result = bus.A & bus.B;
            4'b0111: sc_result = bus.A ^ bus.B;
            4'b1000: sc_result = bus.B >> shamt;
            4'b1001: sc_result = $signed(bus.B) >>> shamt;
            default: sc_result = '0;
        endcase
    end

    // one shift-add (multiply) or restoring-subtract (divide) step; in IDLE it
    // works on the incoming operands so the accept edge does the first step
    always_comb begin
        step_hi  = hi_q;
        step_lo  = lo_q;
        step_b   = b_q;
        step_div = op_div_q;
        if (state_q == IDLE) begin
            step_hi  = '0;
            step_lo  = bus.A;
            step_b   = bus.B;
            step_div = bus.ALUOp[2];
        end
        mul_sum   = {1'b0, step_hi} + (step_lo[0] ? {1'b0, step_b} : '0);
        div_shift = {step_hi, step_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, step_b};
        step_hi_n = mul_sum[WIDTH:1];
        step_lo_n = {mul_sum[0], step_lo[WIDTH-1:1]};
        if (step_div) begin
            if (!div_trial[WIDTH]) begin
                step_hi_n = div_trial[WIDTH-1:0];
                step_lo_n = {step_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_n = div_shift[WIDTH-1:0];
                step_lo_n = {step_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // upper half holds the product high word or the remainder
    assign iter_result = op_hi_q ? step_hi_n : step_lo_n;

    // next-state: enter ITER on an accepted iterative op, leave on the last step
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && iter_op) state_d = ITER;
            ITER:    if (cnt_q == LAST_STEP) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge CLK) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // operand latch, iteration datapath and registered result/flags
    always_ff @(posedge CLK) begin
        if (Reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            op_div_q <= 1'b0;
            op_hi_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (iter_op) begin
                    hi_q     <= step_hi_n;
                    lo_q     <= step_lo_n;
                    b_q      <= bus.B;
                    op_div_q <= bus.ALUOp[2];
                    op_hi_q  <= bus.ALUOp[0];
                    cnt_q    <= ITER_LOAD;
                end else begin
                    result_q <= sc_result;
                    zero_q   <= (sc_result == '0);
                    ovf_q    <= sc_ovf;
                    done_q   <= 1'b1;
                end
            end else if (state_q == ITER) begin
                hi_q  <= step_hi_n;
                lo_q  <= step_lo_n;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == LAST_STEP) begin
                    result_q <= iter_result;
                    zero_q   <= (iter_result == '0);
                    ovf_q    <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.busy      = (state_q == ITER);
    assign bus.done      = done_q;
    assign bus.ALUResult = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
endmodule
